// File: rtl/adc_serial_reader_if.sv
// adc_serial_reader_if: ADC pins plus the parallel sample/status bus of
// adc_serial_reader. The reader binds to the slave modport; the controlling
// logic (EN/DUMMY source, ADC pad model, downstream consumers) uses master.
interface adc_serial_reader_if #(
    parameter int unsigned DATA_BITS = 12
);
    logic                 EN_i;
    logic                 SDO_i;
    logic                 DUMMY_i;
    logic                 CS_o;
    logic                 SCLK_o;
    logic [DATA_BITS-1:0] ADC_o;
    logic                 VALID_o;
    logic                 FRAME_ERR_o;
    logic [7:0]           ERR_CNT_o;
    logic [31:0]          SAMPLE_CNT_o;
    logic                 BUSY_o;

    modport slave (
        input  EN_i, SDO_i, DUMMY_i,
        output CS_o, SCLK_o, ADC_o, VALID_o, FRAME_ERR_o, ERR_CNT_o, SAMPLE_CNT_o, BUSY_o
    );

    modport master (
        output EN_i, SDO_i, DUMMY_i,
        input  CS_o, SCLK_o, ADC_o, VALID_o, FRAME_ERR_o, ERR_CNT_o, SAMPLE_CNT_o, BUSY_o
    );
endinterface

// File: rtl/adc_serial_reader.sv
// adc_serial_reader: drives a 12-bit serial ADC (CS/SCLK/SDO, 16-bit frame with
// 4 leading zeros), runs back-to-back conversions while EN_i is high and
// presents each good sample with a one-cycle VALID_o strobe. Frames whose
// leading bits are not all zero are dropped and counted instead.
// Optional build macro ADC_DUMMY_EN adds an internal decaying test waveform
// selected by DUMMY_i; without it DUMMY_i is unused.
module adc_serial_reader #(
    parameter int unsigned CLK_DIV      = 1,
    parameter int unsigned FRAME_BITS   = 16,
    parameter int unsigned LEAD_ZEROS   = 4,
    parameter int unsigned QUIET_CYCLES = 2
) (
    input  logic              CLK_i,
    input  logic              RST_i,
    adc_serial_reader_if.slave bus
);
    localparam int unsigned DATA_BITS = FRAME_BITS - LEAD_ZEROS;
    localparam int unsigned QUIET_LEN = 2 * CLK_DIV * QUIET_CYCLES;
    localparam int unsigned DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W     = $clog2(FRAME_BITS);
    localparam int unsigned Q_W       = (QUIET_LEN > 1) ? $clog2(QUIET_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASSERT,
        S_SHIFT,
        S_DONE,
        S_QUIET
    } state_t;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_cnt_q, div_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_d;
    logic [Q_W-1:0]        quiet_cnt_q, quiet_d;
    logic                  phase_q, phase_d;   // 0 = SCLK low half, 1 = high half
    logic                  div_last;
    logic                  capture;
    logic                  frame_end;
    logic                  start_frame;
    logic                  cs_d, sclk_d;
    logic                  cs_q, sclk_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic                  lead_bad;
    logic [DATA_BITS-1:0]  frame_data;
    logic [DATA_BITS-1:0]  adc_q;
    logic                  valid_q, err_q, busy_q;
    logic [7:0]            err_cnt_q;
    logic [31:0]           sample_cnt_q;

    assign div_last    = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign start_frame = (state_d == S_ASSERT) && (state_q != S_ASSERT);

    // Next-state, counter and pin-level decode for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        div_d     = div_cnt_q;
        bit_d     = bit_cnt_q;
        quiet_d   = quiet_cnt_q;
        phase_d   = phase_q;
        capture   = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.EN_i) begin
                    state_d = S_ASSERT;
                    div_d   = '0;
                end
            end
            S_ASSERT: begin
                if (div_last) begin
                    state_d = S_SHIFT;
                    div_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                end else begin
                    div_d = div_cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (!div_last) begin
                    div_d = div_cnt_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        capture = 1'b1;
                    end else if (bit_cnt_q == BIT_W'(FRAME_BITS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        phase_d = 1'b0;
                        bit_d   = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d   = S_QUIET;
                quiet_d   = '0;
                frame_end = 1'b1;
            end
            S_QUIET: begin
                if (quiet_cnt_q == Q_W'(QUIET_LEN - 1)) begin
                    state_d = bus.EN_i ? S_ASSERT : S_IDLE;
                    div_d   = '0;
                end else begin
                    quiet_d = quiet_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Pins are registered from the next state so they never glitch.
        cs_d   = !((state_d == S_ASSERT) || (state_d == S_SHIFT));
        sclk_d = !((state_d == S_SHIFT) && !phase_d);
    end

    // Sequencer registers, registered pins and SDO shift register.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_q     <= S_IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            quiet_cnt_q <= '0;
            phase_q     <= 1'b0;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b1;
            busy_q      <= 1'b0;
            shift_q     <= '0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_d;
            bit_cnt_q   <= bit_d;
            quiet_cnt_q <= quiet_d;
            phase_q     <= phase_d;
            cs_q        <= cs_d;
            sclk_q      <= sclk_d;
            busy_q      <= (state_d != S_IDLE);
            if (capture) begin
                shift_q <= {shift_q[FRAME_BITS-2:0], bus.SDO_i};
            end
        end
    end

`ifdef ADC_DUMMY_EN
    logic                 dummy_act_q;
    logic [5:0]           dummy_f_q, dummy_f_d;
    logic [DATA_BITS-1:0] excess_q;

    assign dummy_f_d = dummy_act_q ? dummy_f_q + 6'd1 : 6'd0;

    // Latch the waveform select at each frame start and step the decay generator.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            dummy_act_q <= 1'b0;
            dummy_f_q   <= '0;
            excess_q    <= '0;
        end else if (start_frame) begin
            dummy_act_q <= bus.DUMMY_i;
            if (bus.DUMMY_i) begin
                dummy_f_q <= dummy_f_d;
                excess_q  <= (dummy_f_d == 6'd0) ? DATA_BITS'(1000)
                                                 : excess_q - (excess_q >> 3);
            end
        end
    end
`else
    logic unused_dummy;
    logic unused_start;
    assign unused_dummy = bus.DUMMY_i;
    assign unused_start = start_frame;
`endif

    // Frame verdict: leading-zero check and payload selection.
    always_comb begin
        lead_bad   = |shift_q[FRAME_BITS-1 -: LEAD_ZEROS];
        frame_data = shift_q[DATA_BITS-1:0];
`ifdef ADC_DUMMY_EN
        if (dummy_act_q) begin
            lead_bad   = 1'b0;
            frame_data = DATA_BITS'(550) + excess_q;
        end
`endif
    end

    // Sample output, strobes and statistics, updated from the DONE cycle.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            adc_q        <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
            sample_cnt_q <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (frame_end) begin
                if (!lead_bad) begin
                    adc_q        <= frame_data;
                    valid_q      <= 1'b1;
                    sample_cnt_q <= sample_cnt_q + 32'd1;
                end else begin
                    err_q <= 1'b1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_q <= err_cnt_q + 8'd1;
                    end
                end
            end
        end
    end

    assign bus.CS_o         = cs_q;
    assign bus.SCLK_o       = sclk_q;
    assign bus.ADC_o        = adc_q;
    assign bus.VALID_o      = valid_q;
    assign bus.FRAME_ERR_o  = err_q;
    assign bus.ERR_CNT_o    = err_cnt_q;
    assign bus.SAMPLE_CNT_o = sample_cnt_q;
    assign bus.BUSY_o       = busy_q;
endmodule

// File: tb/tb_adc_serial_reader.sv
// tb_adc_serial_reader: directed bench for adc_serial_reader. A frame-level
// ADC/reference model follows CS/SCLK, serves queued 16-bit words on SDO and
// predicts every output cycle by cycle; directed checks pin frame timing and
// literal sample values. Test-waveform checks run when ADC_DUMMY_EN is defined.
module tb_adc_serial_reader;
    logic CLK_i = 1'b0;
    logic RST_i = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK_i = ~CLK_i;
    always @(posedge CLK_i) cyc++;

    adc_serial_reader_if #(.DATA_BITS(12)) bus ();
    adc_serial_reader_if #(.DATA_BITS(12)) bus3 ();

    adc_serial_reader dut (
        .CLK_i (CLK_i),
        .RST_i (RST_i),
        .bus   (bus)
    );

    adc_serial_reader #(.CLK_DIV(3)) dut3 (
        .CLK_i (CLK_i),
        .RST_i (RST_i),
        .bus   (bus3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- ADC pad model and reference model ----------------
    logic [15:0] sdo_q[$];
    logic [15:0] cur_word = '0;
    int          bit_idx  = 0;
    logic        cs_prev = 1'b1, sclk_prev = 1'b1, in_frame = 1'b0;
    logic [11:0] m_adc = '0, pend_adc = '0;
    logic [7:0]  m_err = '0;
    logic [31:0] m_samples = '0;
    logic        pend_v = 1'b0, pend_e = 1'b0, exp_v, exp_e;
`ifdef ADC_DUMMY_EN
    logic        m_dummy = 1'b0, m_dprev = 1'b0;
    int          m_f = 0;
    int          m_exc = 0;
`endif

    always @(posedge CLK_i) begin
        #1;
        if (RST_i) begin
            m_adc = '0; m_err = '0; m_samples = '0;
            pend_v = 1'b0; pend_e = 1'b0; exp_v = 1'b0; exp_e = 1'b0;
            in_frame = 1'b0; bit_idx = 0; cs_prev = 1'b1; sclk_prev = 1'b1;
`ifdef ADC_DUMMY_EN
            m_dummy = 1'b0; m_dprev = 1'b0; m_f = 0; m_exc = 0;
`endif
        end else begin
            exp_v = pend_v; exp_e = pend_e;
            pend_v = 1'b0; pend_e = 1'b0;
            if (exp_v) begin
                m_adc = pend_adc;
                m_samples = m_samples + 32'd1;
            end
            if (exp_e && m_err != 8'd255) m_err = m_err + 8'd1;
        end
        chk("valid", bus.VALID_o, exp_v);
        chk("frame_err", bus.FRAME_ERR_o, exp_e);
        chk("adc", bus.ADC_o, m_adc);
        chk("err_cnt", bus.ERR_CNT_o, m_err);
        chk("sample_cnt", bus.SAMPLE_CNT_o, m_samples);
        if (!RST_i) begin
            if (cs_prev && !bus.CS_o) begin
                in_frame = 1'b1;
                bit_idx  = 0;
                cur_word = (sdo_q.size() != 0) ? sdo_q.pop_front() : 16'h0000;
`ifdef ADC_DUMMY_EN
                if (bus.DUMMY_i) begin
                    m_f   = m_dprev ? m_f + 1 : 0;
                    m_exc = (m_f % 64 == 0) ? 1000 : m_exc - m_exc / 8;
                end
                m_dummy = bus.DUMMY_i;
                m_dprev = bus.DUMMY_i;
`endif
            end else if (!bus.CS_o && bus.SCLK_o && !sclk_prev) begin
                bit_idx++;
            end else if (!cs_prev && bus.CS_o && in_frame) begin
                in_frame = 1'b0;
                if (cur_word[15:12] == 4'd0) begin
                    pend_v = 1'b1;
                    pend_adc = cur_word[11:0];
                end else begin
                    pend_e = 1'b1;
                end
`ifdef ADC_DUMMY_EN
                if (m_dummy) begin
                    pend_v = 1'b1; pend_e = 1'b0;
                    pend_adc = 12'(550 + m_exc);
                end
`endif
            end
            cs_prev   = bus.CS_o;
            sclk_prev = bus.SCLK_o;
        end
        bus.SDO_i = (bit_idx < 16) ? cur_word[15 - bit_idx] : 1'b0;
    end

    // ---------------- bounded event waits ----------------
    localparam int EV_CS_FALL   = 0;
    localparam int EV_VALID     = 1;
    localparam int EV_ERR       = 2;
    localparam int EV3_CS_FALL  = 3;
    localparam int EV3_CS_RISE  = 4;
    localparam int EV3_VALID    = 5;
    localparam int EV3_SCLK_UP  = 6;
    localparam int EV_CS_LOW    = 7;

    task automatic wait_ev(input string name, input int ev, input int budget, output int t);
        logic pc, pc3, ps3, hit, found;
        pc = bus.CS_o; pc3 = bus3.CS_o; ps3 = bus3.SCLK_o;
        t = -1; found = 1'b0;
        for (int n = 0; n < budget && !found; n++) begin
            @(negedge CLK_i);
            case (ev)
                EV_CS_FALL:  hit = pc && !bus.CS_o;
                EV_VALID:    hit = bus.VALID_o;
                EV_ERR:      hit = bus.FRAME_ERR_o;
                EV3_CS_FALL: hit = pc3 && !bus3.CS_o;
                EV3_CS_RISE: hit = !pc3 && bus3.CS_o;
                EV3_VALID:   hit = bus3.VALID_o;
                EV3_SCLK_UP: hit = !ps3 && bus3.SCLK_o;
                default:     hit = 1'b0;
            endcase
            pc = bus.CS_o; pc3 = bus3.CS_o; ps3 = bus3.SCLK_o;
            if (hit) begin
                t = cyc;
                found = 1'b1;
            end
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL %s: event not seen within %0d cycles, got none required one", name, budget);
        end
    endtask

    task automatic count_ev(input int ev, input int ncyc, output int cnt, output logic [11:0] last_adc);
        cnt = 0; last_adc = '0;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge CLK_i);
            if (ev == EV_VALID && bus.VALID_o) begin
                cnt++;
                last_adc = bus.ADC_o;
            end
            if (ev == EV_CS_LOW && !bus.CS_o) cnt++;
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no end of run, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int t0, t1, t2, t3, n, c;
        logic [11:0] la;
`ifdef ADC_DUMMY_EN
        logic [11:0] dv[66];
`endif
        bus.EN_i = 1'b0; bus.DUMMY_i = 1'b0;
        bus3.EN_i = 1'b0; bus3.SDO_i = 1'b0; bus3.DUMMY_i = 1'b0;
        RST_i = 1'b1;
        repeat (3) @(negedge CLK_i);

        chk("rst_cs", bus.CS_o, 1);
        chk("rst_sclk", bus.SCLK_o, 1);
        chk("rst_adc", bus.ADC_o, 0);
        chk("rst_valid", bus.VALID_o, 0);
        chk("rst_err", bus.FRAME_ERR_o, 0);
        chk("rst_counts", {bus.ERR_CNT_o, bus.SAMPLE_CNT_o[23:0]}, 0);
        chk("rst_busy", bus.BUSY_o, 0);
        RST_i = 1'b0;

        sdo_q.push_back(16'h0ABC);
        sdo_q.push_back(16'h8123);
        sdo_q.push_back(16'h0555);
        for (int i = 0; i < 255; i++) sdo_q.push_back(16'hF000 | 16'(i * 13));
        sdo_q.push_back(16'h0FFF);
        sdo_q.push_back(16'h0000);
        sdo_q.push_back(16'h4000);
        sdo_q.push_back(16'h0001);
        sdo_q.push_back(16'h2ABC);
        sdo_q.push_back(16'h0800);
`ifndef ADC_DUMMY_EN
        bus.DUMMY_i = 1'b1;
`endif
        @(negedge CLK_i);
        bus.EN_i = 1'b1;

        // First conversion latency and back-to-back spacing.
        wait_ev("cs_fall_first", EV_CS_FALL, 10, t0);
        wait_ev("valid_first", EV_VALID, 60, t1);
        chk("first_valid_latency", t1 - t0, 34);
        chk("adc_first", bus.ADC_o, 12'hABC);
        chk("sample_cnt_first", bus.SAMPLE_CNT_o, 1);
        wait_ev("err_first", EV_ERR, 60, t2);
        chk("err_spacing", t2 - t1, 38);
        chk("adc_held_on_err", bus.ADC_o, 12'hABC);
        chk("err_cnt_first", bus.ERR_CNT_o, 1);
        wait_ev("valid_second", EV_VALID, 60, t3);
        chk("valid_spacing", t3 - t2, 38);
        chk("adc_second", bus.ADC_o, 12'h555);

        // Error counter saturation over a long run of bad frames.
        for (int i = 0; i < 255; i++) begin
            wait_ev("err_burst", EV_ERR, 60, t0);
            if (i == 253) chk("err_cnt_reach_255", bus.ERR_CNT_o, 255);
            if (i == 254) chk("err_cnt_saturated", bus.ERR_CNT_o, 255);
        end

        n = 0;
        while (sdo_q.size() != 0 && n < 2000) begin
            @(negedge CLK_i);
            n++;
        end
        chk("queue_drained", sdo_q.size(), 0);

        // EN dropped during bit 5: that frame still completes, then stop.
        sdo_q.push_back(16'h0321);
        wait_ev("cs_fall_en_drop", EV_CS_FALL, 60, t0);
        repeat (11) @(negedge CLK_i);
        bus.EN_i = 1'b0;
        count_ev(EV_VALID, 60, c, la);
        chk("en_drop_one_valid", c, 1);
        chk("en_drop_adc", la, 12'h321);
        count_ev(EV_CS_LOW, 60, c, la);
        chk("en_drop_cs_stays_high", c, 0);
        chk("en_drop_busy", bus.BUSY_o, 0);

        // Single-cycle EN pulse while idle gives exactly one frame.
        sdo_q.push_back(16'h0777);
        bus.EN_i = 1'b1;
        @(negedge CLK_i);
        bus.EN_i = 1'b0;
        count_ev(EV_VALID, 120, c, la);
        chk("pulse_one_valid", c, 1);
        chk("pulse_adc", la, 12'h777);

        // Reset during bit 8 aborts the frame.
        sdo_q.push_back(16'h0999);
        bus.EN_i = 1'b1;
        wait_ev("cs_fall_reset", EV_CS_FALL, 60, t0);
        repeat (17) @(negedge CLK_i);
        RST_i = 1'b1;
        @(negedge CLK_i);
        chk("midrst_cs", bus.CS_o, 1);
        chk("midrst_sclk", bus.SCLK_o, 1);
        chk("midrst_adc", bus.ADC_o, 0);
        chk("midrst_valid", bus.VALID_o, 0);
        chk("midrst_err_cnt", bus.ERR_CNT_o, 0);
        chk("midrst_sample_cnt", bus.SAMPLE_CNT_o, 0);
        RST_i = 1'b0;
        bus.EN_i = 1'b0;
        count_ev(EV_VALID, 60, c, la);
        chk("midrst_no_valid", c, 0);

        // CLK_DIV=3 instance timing.
        bus3.EN_i = 1'b1;
        wait_ev("div3_cs_fall", EV3_CS_FALL, 10, t0);
        wait_ev("div3_sclk_up_a", EV3_SCLK_UP, 20, t1);
        wait_ev("div3_sclk_up_b", EV3_SCLK_UP, 20, t2);
        chk("div3_sclk_period", t2 - t1, 6);
        wait_ev("div3_cs_rise", EV3_CS_RISE, 120, t3);
        chk("div3_cs_low", t3 - t0, 99);
        wait_ev("div3_valid_a", EV3_VALID, 10, t1);
        chk("div3_valid_latency", t1 - t0, 100);
        wait_ev("div3_valid_b", EV3_VALID, 150, t2);
        chk("div3_valid_spacing", t2 - t1, 112);
        chk("div3_frame_err", bus3.FRAME_ERR_o, 0);
        bus3.EN_i = 1'b0;
        repeat (150) @(negedge CLK_i);

`ifdef ADC_DUMMY_EN
        // Internal test waveform: SDO content is irrelevant.
        for (int i = 0; i < 70; i++) sdo_q.push_back(16'hF0F0);
        bus.DUMMY_i = 1'b1;
        bus.EN_i = 1'b1;
        for (int f = 0; f < 66; f++) begin
            wait_ev("dummy_valid", EV_VALID, 60, t0);
            dv[f] = bus.ADC_o;
        end
        bus.EN_i = 1'b0;
        chk("dummy_f0", dv[0], 1550);
        chk("dummy_f1", dv[1], 1425);
        chk("dummy_f2", dv[2], 1316);
        chk("dummy_f64", dv[64], 1550);
        chk("dummy_err_cnt", bus.ERR_CNT_o, 0);
        repeat (60) @(negedge CLK_i);
        bus.DUMMY_i = 1'b0;
`endif

        repeat (5) @(negedge CLK_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
